// File: rtl/ledr_pwm_pkg.sv
// ledr_pwm_pkg: register map, reset values and CTRL bit positions
// shared by the LEDR PWM driver.
package ledr_pwm_pkg;

   typedef enum logic [1:0] {
      LEDR_ADDR_BRIGHT = 2'd0,
      LEDR_ADDR_MASK   = 2'd1,
      LEDR_ADDR_HALF   = 2'd2,
      LEDR_ADDR_CTRL   = 2'd3
   } ledr_addr_e;

   localparam logic [31:0] LEDR_RST_BRIGHT = 32'h0000_00FF;
   localparam logic [31:0] LEDR_RST_MASK   = 32'h0000_0000;
   localparam logic [15:0] LEDR_RST_HALF   = 16'h0000;
   localparam logic        LEDR_RST_ENABLE = 1'b1;
   localparam logic        LEDR_RST_PHASE  = 1'b1;

   localparam int LEDR_CTRL_ENABLE = 0;
   localparam int LEDR_CTRL_PHASE  = 1;

endpackage

// File: rtl/ledr_tick_gen.sv
// ledr_tick_gen: blink prescaler, one-cycle tick every PRESCALE clocks
// (asserted while the count sits at PRESCALE-1, i.e. on the wrap).
module ledr_tick_gen #(
   parameter int PRESCALE = 50000
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int CW = $clog2(PRESCALE);
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/ledr_pwm_driver.sv
// ledr_pwm_driver: LEDR pin stage with PWM brightness, blink mask, enable.
// Define LEDR_PWM_GAMMA_EN for a square-law brightness curve.
module ledr_pwm_driver
   import ledr_pwm_pkg::*;
#(
   parameter int WIDTH    = 18,
   parameter int PWM_BITS = 8,
   parameter int PRESCALE = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] led_in,
   output logic [WIDTH-1:0] led_out
);

   logic                wr;
   logic                sel_bright;
   logic                sel_mask;
   logic                sel_half;
   logic                sel_ctrl;
   logic [PWM_BITS-1:0] bright;
   logic [WIDTH-1:0]    mask;
   logic [15:0]         half;
   logic                enable;
   logic                phase;
   logic [15:0]         blink_cnt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] duty;
   logic                pwm_on;
   logic                tick;
   logic                expire;
   logic                half_wr;
   logic                unused_wd;

   assign sel_bright = (address == LEDR_ADDR_BRIGHT);
   assign sel_mask   = (address == LEDR_ADDR_MASK);
   assign sel_half   = (address == LEDR_ADDR_HALF);
   assign sel_ctrl   = (address == LEDR_ADDR_CTRL);
   assign wr         = chipselect & ~write_n;
   assign half_wr    = wr & sel_half;
   assign unused_wd  = ^writedata;

   ledr_tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bright <= LEDR_RST_BRIGHT[PWM_BITS-1:0];
         mask   <= LEDR_RST_MASK[WIDTH-1:0];
         half   <= LEDR_RST_HALF;
         enable <= LEDR_RST_ENABLE;
      end else if (wr) begin
         unique case (1'b1)
            sel_bright: bright <= writedata[PWM_BITS-1:0];
            sel_mask:   mask   <= writedata[WIDTH-1:0];
            sel_half:   half   <= writedata[15:0];
            sel_ctrl:   enable <= writedata[LEDR_CTRL_ENABLE];
            default:    ;
         endcase
      end
   end

`ifdef LEDR_PWM_GAMMA_EN
   logic [2*PWM_BITS-1:0] bright_sq;

   assign bright_sq = {{PWM_BITS{1'b0}}, bright} *
                      {{PWM_BITS{1'b0}}, bright};
   assign duty      = (&bright) ? '1 :
                      bright_sq[2*PWM_BITS-1:PWM_BITS];
`else
   assign duty = bright;
`endif

   // all-ones duty is fully on, otherwise the compare leaves one gap
   assign pwm_on = (&duty) | (pwm_cnt < duty);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
   end

   assign expire = tick & (half != 16'd0) &
                   (blink_cnt == half - 16'd1);

   // a BLINK_HALF write restarts the blink ahead of any tick or expiry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt <= '0;
         phase     <= LEDR_RST_PHASE;
      end else if (half_wr | (half == 16'd0)) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (expire) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else if (tick) begin
         blink_cnt <= blink_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         led_out <= '0;
      end else begin
         led_out <= {WIDTH{enable & pwm_on}} & led_in &
                    (~mask | {WIDTH{phase}});
      end
   end

   always_comb begin
      readdata = '0;
      unique case (1'b1)
         sel_bright: readdata[PWM_BITS-1:0] = bright;
         sel_mask:   readdata[WIDTH-1:0]    = mask;
         sel_half:   readdata[15:0]         = half;
         sel_ctrl: begin
            readdata[LEDR_CTRL_ENABLE] = enable;
            readdata[LEDR_CTRL_PHASE]  = phase;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ledr_pwm_driver.sv
// tb_ledr_pwm_driver: table, directed and random checks of ledr_pwm_driver
// against a cycle-count reference model (PRESCALE = 4, PWM_BITS = 8).
module tb_ledr_pwm_driver;

   localparam int W  = 18;
   localparam int PB = 8;
   localparam int P  = 4;
`ifdef LEDR_PWM_GAMMA_EN
   localparam int PWM_HIGH = 16;
`else
   localparam int PWM_HIGH = 64;
`endif

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rexp;
      string       name;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [1:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic [W-1:0]  led_in;
   logic [W-1:0]  led_out;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   ledr_pwm_driver #(
      .WIDTH    (W),
      .PWM_BITS (PB),
      .PRESCALE (P)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .led_in     (led_in),
      .led_out    (led_out)
   );

   always #5 clk = ~clk;

   // reference model: state is edges since reset plus last restart edge
   int unsigned   cyc;
   int unsigned   t0;
   logic [PB-1:0] m_bright;
   logic [W-1:0]  m_mask;
   logic [15:0]   m_half;
   logic          m_en;
   logic [W-1:0]  exp_led;

   function automatic logic [PB-1:0] m_duty(input logic [PB-1:0] b);
`ifdef LEDR_PWM_GAMMA_EN
      int sq;
      if (b == 8'hFF) return 8'hFF;
      sq = int'(b) * int'(b);
      return PB'(sq / 256);
`else
      return b;
`endif
   endfunction

   function automatic int unsigned m_ticks(input int unsigned e);
      return e / P - t0 / P;
   endfunction

   function automatic logic m_phase(input int unsigned e);
      if (m_half == 16'd0) return 1'b1;
      return ((m_ticks(e) / m_half) % 2) == 0;
   endfunction

   function automatic int unsigned m_bcnt(input int unsigned e);
      if (m_half == 16'd0) return 0;
      return m_ticks(e) % m_half;
   endfunction

   function automatic logic [W-1:0] m_led(input int unsigned e,
                                          input logic [W-1:0] din);
      logic [PB-1:0] dt;
      dt = m_duty(m_bright);
      if (!m_en) return '0;
      if (dt != 8'hFF && (e % 256) >= dt) return '0;
      return din & (~m_mask | {W{m_phase(e)}});
   endfunction

   function automatic logic [31:0] exp_read(input logic [1:0] a);
      case (a)
         2'd0:    return {24'd0, m_bright};
         2'd1:    return {14'd0, m_mask};
         2'd2:    return {16'd0, m_half};
         default: return {30'd0, m_phase(cyc), m_en};
      endcase
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc      <= 0;
         t0       <= 0;
         m_bright <= 8'hFF;
         m_mask   <= '0;
         m_half   <= 16'd0;
         m_en     <= 1'b1;
         exp_led  <= '0;
      end else begin
         cyc     <= cyc + 1;
         exp_led <= m_led(cyc, led_in);
         if (chipselect && !write_n) begin
            case (address)
               2'd0: m_bright <= writedata[PB-1:0];
               2'd1: m_mask   <= writedata[W-1:0];
               2'd2: begin
                  m_half <= writedata[15:0];
                  t0     <= cyc + 1;
               end
               default: m_en <= writedata[0];
            endcase
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model led_out", 32'(led_out), 32'(exp_led));
         check("model readdata", readdata, exp_read(address));
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      step();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[11];
      logic [31:0] d;
      logic [31:0] r;
      int          cnt;
      int          run;
      int          zeros;
      logic        prev;
      bit          found;

      tbl[0]  = '{2'd2, 32'h0001_2345, 32'h0000_2345, "tbl half"};
      tbl[1]  = '{2'd0, 32'h00AB_CD12, 32'h0000_0012, "tbl bright"};
      tbl[2]  = '{2'd0, 32'h0000_01FF, 32'h0000_00FF, "tbl bright ff"};
      tbl[3]  = '{2'd1, 32'hFFFF_FFFF, 32'h0003_FFFF, "tbl mask all"};
      tbl[4]  = '{2'd1, 32'h0001_5555, 32'h0001_5555, "tbl mask alt"};
      tbl[5]  = '{2'd3, 32'h0000_0000, 32'h0000_0002, "tbl ctrl 0"};
      tbl[6]  = '{2'd3, 32'hFFFF_FFFD, 32'h0000_0003, "tbl ctrl ro"};
      tbl[7]  = '{2'd3, 32'h0000_0002, 32'h0000_0002, "tbl ctrl 2"};
      tbl[8]  = '{2'd3, 32'h0000_0001, 32'h0000_0003, "tbl ctrl 1"};
      tbl[9]  = '{2'd1, 32'h0000_0000, 32'h0000_0000, "tbl mask 0"};
      tbl[10] = '{2'd2, 32'h0000_0000, 32'h0000_0000, "tbl half 0"};

      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      led_in     = 18'h3FFFF;
      step(3);
      chk_en  = 1'b1;
      reset_n = 1'b1;

      // reset release
      step();
      check("reset led first", 32'(led_out), 32'h3FFFF);
      step(3);
      check("reset led steady", 32'(led_out), 32'h3FFFF);
      rd(2'd0, d);
      check("reset bright", d, 32'hFF);
      rd(2'd3, d);
      check("reset ctrl", d, 32'h3);
      step();

      for (int i = 0; i < 11; i++) begin
         wr(tbl[i].addr, tbl[i].wdata);
         rd(tbl[i].addr, d);
         check(tbl[i].name, d, tbl[i].rexp);
      end

      // PWM duty over one full period
      led_in = 18'h1;
      wr(2'd0, 32'h40);
      step(2);
      cnt = 0;
      for (int i = 0; i < 256; i++) begin
         if (led_out[0]) cnt++;
         step();
      end
      check("pwm duty count", 32'(cnt), 32'(PWM_HIGH));

      // blink of masked bit 1, bit 0 steady
      wr(2'd0, 32'hFF);
      led_in = 18'h3;
      wr(2'd1, 32'h2);
      wr(2'd2, 32'h2);
      zeros = 0;
      found = 1'b0;
      prev  = led_out[1];
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (!led_out[0]) zeros++;
         if (led_out[1] !== prev) found = 1'b1;
      end
      check("blink first toggle", 32'(found), 32'd1);
      for (int k = 0; k < 3; k++) begin
         prev = led_out[1];
         run  = 0;
         do begin
            step();
            run++;
            if (!led_out[0]) zeros++;
         end while (led_out[1] === prev && run < 20);
         check("blink half run", 32'(run), 32'd8);
      end
      check("blink unmasked steady", 32'(zeros), 32'd0);

      // BLINK_HALF write landing on an expiry edge
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (((cyc + 1) % P == 0) && m_bcnt(cyc) == 1) found = 1'b1;
         else step();
      end
      check("collision aligned", 32'(found), 32'd1);
      wr(2'd2, 32'h2);
      rd(2'd3, d);
      check("collision phase at write", 32'(d[1]), 32'd1);
      step(4);
      rd(2'd3, d);
      check("collision first tick", 32'(d[1]), 32'd1);
      step(3);
      rd(2'd3, d);
      check("collision before 2nd tick", 32'(d[1]), 32'd1);
      step();
      rd(2'd3, d);
      check("collision second tick", 32'(d[1]), 32'd0);

      // enable off and back on
      wr(2'd2, 32'h0);
      wr(2'd1, 32'h0);
      led_in = 18'h3FFFF;
      step(2);
      wr(2'd3, 32'h0);
      check("enable off write edge", 32'(led_out), 32'h3FFFF);
      step();
      check("enable off 2nd cycle", 32'(led_out), 32'h0);
      rd(2'd3, d);
      check("ctrl phase read-only", d, 32'h2);
      step(3);
      check("enable off holds", 32'(led_out), 32'h0);
      wr(2'd3, 32'h1);
      check("enable on write edge", 32'(led_out), 32'h0);
      step();
      check("enable restored", 32'(led_out), 32'h3FFFF);

      // asynchronous reset in the middle of a blink
      wr(2'd1, 32'h2);
      wr(2'd2, 32'h3);
      wr(2'd0, 32'h55);
      wr(2'd0, 32'hFF);
      step(10);
      check("pre-reset led0", 32'(led_out[0]), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async reset led", 32'(led_out), 32'h0);
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), d);
         case (a)
            0:       r = 32'hFF;
            3:       r = 32'h3;
            default: r = 32'h0;
         endcase
         check("reset reg value", d, r);
         step();
      end
      reset_n = 1'b1;
      step(2);

      // randomized traffic against the model
      for (int i = 0; i < 2500; i++) begin
         led_in     = W'($urandom);
         address    = 2'($urandom_range(0, 3));
         chipselect = 1'($urandom_range(0, 1));
         write_n    = ($urandom_range(0, 3) != 0);
         case (address)
            2'd0: begin
               case ($urandom_range(0, 3))
                  0:       writedata = 32'h0;
                  1:       writedata = 32'hFF;
                  default: writedata = $urandom;
               endcase
            end
            2'd2: writedata = ($urandom & 32'hFFFF_0000) |
                              32'($urandom_range(0, 3));
            default: writedata = $urandom;
         endcase
         step();
      end
      chipselect = 1'b0;
      write_n    = 1'b1;
      step(2);
      chk_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
